serial_subtractor: RTL and testbench

Bit-serial 4-bit subtractor computing `in1 - in2` one bit per clock using a single borrow flip-flop. It is the sequential, inverse-direction companion to the combinational `adder`, with the same operand names and widths. It uses a start/done handshake so a lab top-level or bench can launch an operation and wait for the result. Intended for the next lab exercise on datapath-plus-FSM design.

---
 rtl/serial_subtractor_if.sv | 15 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor: operands in, registered result and status out.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out1;
    logic             borrow;
    logic             busy;
    logic             done;

    modport master (output start, in1, in2, input out1, borrow, busy, done);
    modport slave  (input start, in1, in2, output out1, borrow, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial in1 - in2, one bit per clock through a single borrow flop, start/done handshake.
// Optional macro SERIAL_SUBTRACTOR_SATURATE_EN clamps a borrowing result to zero.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out1;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;

    logic             w_last;
    logic             w_d;
    logic             w_bw_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_d        = r_a[0] ^ r_b[0] ^ r_bw;
    assign w_bw_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bw);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_next = S_DONE;
            S_DONE:                 w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Datapath; the last shift also lands the result so it is visible throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_out1   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.in1;
                        r_b   <= bus.in2;
                        r_res <= '0;
                        r_bw  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_bw  <= w_bw_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
                        r_out1 <= w_bw_next ? '0 : w_res_next;
`else
                        r_out1 <= w_res_next;
`endif
                        r_borrow <= w_bw_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags registered from the next state so they align with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign bus.out1   = r_out1;
    assign bus.borrow = r_borrow;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: timestamp-based reference model plus directed literal checks and random traffic.
module tb_serial_subtractor;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start at edge e publishes its result at edge e+W and frees the block at e+W+2.
    int           e      = 0;
    int           free_e = 0;
    int           done_e = -1;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_out, p_out;
    logic         m_bor, p_bor, m_busy, m_done;

    always @(posedge clk) begin
        int diff;
        e++;
        if (rst) begin
            m_valid = 1'b1;
            m_out   = '0;
            m_bor   = 1'b0;
            done_e  = -1;
            free_e  = e + 1;
        end else begin
            if (e == done_e) begin
                m_out = p_out;
                m_bor = p_bor;
            end
            if (bus.start && e >= free_e) begin
                diff  = int'(bus.in1) - int'(bus.in2);
                p_bor = (diff < 0);
                p_out = W'(diff);
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
                if (p_bor) p_out = '0;
`endif
                done_e = e + W;
                free_e = e + W + 2;
            end
        end
        m_done = !rst && (e == done_e);
        m_busy = (free_e > e + 1);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("out1",   32'(bus.out1),   32'(m_out));
            chk("borrow", 32'(bus.borrow), 32'(m_bor));
            chk("busy",   32'(bus.busy),   32'(m_busy));
            chk("done",   32'(bus.done),   32'(m_done));
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp_o, input logic exp_b, input string nm);
        int lat;
        @(negedge clk);
        bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.done === 1'b1) break;
        end
        chk({nm, "_lat"},    32'(lat),        32'(W + 1));
        chk({nm, "_out1"},   32'(bus.out1),   32'(exp_o));
        chk({nm, "_borrow"}, 32'(bus.borrow), 32'(exp_b));
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        int last_done;
        rst = 1'b1; bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out1", 32'(bus.out1), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        op(4'b1001, 4'b0110, 4'b0011, 1'b0, "t9m6");
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
        op(4'b0011, 4'b1111, 4'b0000, 1'b1, "t3m15");
        op(4'b0000, 4'b0001, 4'b0000, 1'b1, "t0m1");
`else
        op(4'b0011, 4'b1111, 4'b0100, 1'b1, "t3m15");
        op(4'b0000, 4'b0001, 4'b1111, 1'b1, "t0m1");
`endif
        op(4'b1010, 4'b1010, 4'b0000, 1'b0, "t10m10");

        // Start pulse and operand change while busy must not disturb the captured operation.
        @(negedge clk);
        bus.in1 = 4'b1001; bus.in2 = 4'b0110; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.in1 = 4'b0000; bus.in2 = 4'b1111; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("ignore_start_ndone", 32'(ndone), 32'd1);
        chk("ignore_start_out1", 32'(bus.out1), 32'(4'b0011));

        // Reset in the third SHIFT cycle discards the operation.
        @(negedge clk);
        bus.in1 = 4'b0111; bus.in2 = 4'b0010; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy",   32'(bus.busy),   32'd0);
        chk("midrst_out1",   32'(bus.out1),   32'd0);
        chk("midrst_borrow", 32'(bus.borrow), 32'd0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("midrst_ndone", 32'(ndone), 32'd0);

        // Start held high: one result every W+2 cycles.
        last_done = -1;
        ndone = 0;
        bus.start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.in1 = W'($urandom); bus.in2 = W'($urandom);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (last_done >= 0) chk("b2b_spacing", 32'(c - last_done), 32'(W + 2));
                last_done = c;
                ndone++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count_min", 32'(ndone >= 5), 32'd1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            bus.start = ($urandom_range(0, 99) < 35);
            bus.in1   = W'($urandom);
            bus.in2   = W'($urandom);
            rst       = ($urandom_range(0, 99) < 2);
            @(negedge clk);
        end
        rst = 1'b0; bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
